// File: rtl/alu_mc.sv
// Multi-cycle ALU for the execute stage: one operation in flight, valid/ready on both sides,
// iterative restoring divider and counted-latency multiplier behind a registered result.
module alu_mc #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_result
);

  localparam int unsigned ShW    = $clog2(WIDTH);
  localparam int unsigned CntMax = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic [WIDTH-1:0]  dvsr_q, dvsr_d;
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              is_div_q, is_div_d;
  logic              is_rem_q, is_rem_d;
  logic [WIDTH-1:0]  alu_result_q, alu_result_d;
  logic              out_valid_q, out_valid_d;

  logic                      accept;
  logic [ShW-1:0]            shamt;
  logic [WIDTH-1:0]          simple_res;
  logic signed [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH-1:0]          mul_res;
  logic [WIDTH-1:0]          mag1, mag2;
  logic [WIDTH:0]            trial;
  logic [WIDTH-1:0]          quot_step, rem_step;
  logic [WIDTH-1:0]          quot_fin, rem_fin;

  assign in_ready   = !flush && (state_q == StIdle || (state_q == StDone && out_ready));
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign alu_result = alu_result_q;
  assign shamt      = op2[ShW-1:0];

  always_comb begin
    simple_res = '0;
    case (alu_op)
      4'b0000: simple_res = op1 << shamt;
      4'b0001: simple_res = op1 >> shamt;
      4'b0010: simple_res = $signed(op1) >>> shamt;
      4'b0011: simple_res = op1 + op2;
      4'b0100: simple_res = op1 - op2;
      4'b0101: simple_res = op1 & op2;
      4'b0110: simple_res = op1 | op2;
      4'b0111: simple_res = op1 ^ op2;
      4'b1000: simple_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      4'b1001: simple_res = {{(WIDTH-1){1'b0}}, op1 == op2};
      4'b1010: simple_res = {{(WIDTH-1){1'b0}}, op1 != op2};
      4'b1011: simple_res = {{(WIDTH-1){1'b0}}, op1 < op2};
      default: simple_res = '0;
    endcase
  end

  // Product is formed at accept; the counter only models the multiplier latency.
  assign mul_a   = {{WIDTH{op1[WIDTH-1]}}, op1};
  assign mul_b   = {{WIDTH{op2[WIDTH-1]}}, op2};
  assign prod    = mul_a * mul_b;
  assign mul_res = alu_op[0] ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];

  assign mag1 = op1[WIDTH-1] ? -op1 : op1;
  assign mag2 = op2[WIDTH-1] ? -op2 : op2;

  // One restoring step; rem_q never has its MSB set, so the shifted value fits WIDTH+1 bits.
  assign trial     = {rem_q, quot_q[WIDTH-1]} - {1'b0, dvsr_q};
  assign rem_step  = trial[WIDTH] ? {rem_q[WIDTH-2:0], quot_q[WIDTH-1]} : trial[WIDTH-1:0];
  assign quot_step = {quot_q[WIDTH-2:0], ~trial[WIDTH]};
  assign quot_fin  = qneg_q ? -quot_step : quot_step;
  assign rem_fin   = rneg_q ? -rem_step : rem_step;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    dvsr_d       = dvsr_q;
    qneg_d       = qneg_q;
    rneg_d       = rneg_q;
    is_div_d     = is_div_q;
    is_rem_d     = is_rem_q;
    alu_result_d = alu_result_q;
    out_valid_d  = out_valid_q;

    unique case (state_q)
      StIdle: begin
      end
      StBusy: begin
        cnt_d = cnt_q - CntW'(1);
        if (is_div_q) begin
          quot_d = quot_step;
          rem_d  = rem_step;
        end
        if (cnt_q == CntW'(1)) begin
          state_d      = StDone;
          out_valid_d  = 1'b1;
          alu_result_d = is_div_q ? (is_rem_q ? rem_fin : quot_fin) : quot_q;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      if (alu_op[3:2] != 2'b11) begin
        state_d      = StDone;
        out_valid_d  = 1'b1;
        alu_result_d = simple_res;
      end else if (!alu_op[1]) begin
        is_div_d = 1'b0;
        quot_d   = mul_res;
        if (MUL_CYCLES == 1) begin
          state_d      = StDone;
          out_valid_d  = 1'b1;
          alu_result_d = mul_res;
        end else begin
          state_d     = StBusy;
          out_valid_d = 1'b0;
          cnt_d       = CntW'(MUL_CYCLES - 1);
        end
      end else begin
        // Divide-by-zero keeps the all-ones raw quotient; overflow falls out of the magnitudes.
        state_d     = StBusy;
        out_valid_d = 1'b0;
        cnt_d       = CntW'(WIDTH);
        is_div_d    = 1'b1;
        is_rem_d    = alu_op[0];
        quot_d      = mag1;
        rem_d       = '0;
        dvsr_d      = mag2;
        qneg_d      = (op1[WIDTH-1] ^ op2[WIDTH-1]) && (op2 != '0);
        rneg_d      = op1[WIDTH-1];
      end
    end

    if (flush) begin
      state_d     = StIdle;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      dvsr_q       <= '0;
      qneg_q       <= 1'b0;
      rneg_q       <= 1'b0;
      is_div_q     <= 1'b0;
      is_rem_q     <= 1'b0;
      alu_result_q <= '0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      dvsr_q       <= dvsr_d;
      qneg_q       <= qneg_d;
      rneg_q       <= rneg_d;
      is_div_q     <= is_div_d;
      is_rem_q     <= is_rem_d;
      alu_result_q <= alu_result_d;
      out_valid_q  <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc (WIDTH=32, MUL_CYCLES=3) with hand-computed expected results.
module tb_alu_mc;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_result;

  int errors = 0;
  int checks = 0;

  alu_mc #(
    .WIDTH(32),
    .MUL_CYCLES(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_result(alu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one op with out_ready=1 and checks it appears exactly lat cycles after accept.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int lat, input logic [31:0] exp);
    logic early;
    logic rdy_busy;
    early     = 1'b0;
    rdy_busy  = 1'b0;
    alu_op    = op;
    op1       = a;
    op2       = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    op1      = 32'hDEAD_BEEF;
    op2      = 32'h0000_0001;
    for (int i = 1; i < lat; i++) begin
      if (out_valid) early = 1'b1;
      if (in_ready) rdy_busy = 1'b1;
      tick();
    end
    chk({tag, "_early"}, {31'd0, early}, 32'd0);
    chk({tag, "_rdy_busy"}, {31'd0, rdy_busy}, 32'd0);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(tag, alu_result, exp);
    tick();
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b1;
    alu_op    = 4'b0011;
    op1       = 32'd1;
    op2       = 32'd1;
    out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", alu_result, 32'd0);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rst_no_accept", {31'd0, out_valid}, 32'd0);

    // Back-to-back simple ops
    in_valid = 1'b1;
    alu_op = 4'b0011; op1 = 32'hFFFF_FFFF; op2 = 32'h0000_0001;
    tick();
    chk("add_v", {31'd0, out_valid}, 32'd1);
    chk("add", alu_result, 32'h0000_0000);
    alu_op = 4'b0010; op1 = 32'h8000_0000; op2 = 32'h0000_0021;
    tick();
    chk("sra_v", {31'd0, out_valid}, 32'd1);
    chk("sra", alu_result, 32'hC000_0000);
    alu_op = 4'b1011; op1 = 32'h0000_0001; op2 = 32'hFFFF_FFFF;
    tick();
    chk("sltu_v", {31'd0, out_valid}, 32'd1);
    chk("sltu", alu_result, 32'h0000_0001);
    in_valid = 1'b0;
    tick();
    chk("b2b_drain", {31'd0, out_valid}, 32'd0);

    run_op("mul", 4'b1100, 32'h1234_5678, 32'h0000_0010, 3, 32'h2345_6780);
    run_op("mulh", 4'b1101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3, 32'h0000_0000);
    run_op("div_neg", 4'b1110, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFD);
    run_op("rem_neg", 4'b1111, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF);
    run_op("div_zero", 4'b1110, 32'h0000_0005, 32'h0000_0000, 33, 32'hFFFF_FFFF);
    run_op("rem_zero", 4'b1111, 32'h0000_0005, 32'h0000_0000, 33, 32'h0000_0005);
    run_op("div_ovf", 4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000);
    run_op("rem_ovf", 4'b1111, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000);
    run_op("div_pos", 4'b1110, 32'd100, 32'd7, 33, 32'd14);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    alu_op = 4'b0111; op1 = 32'hA5A5_A5A5; op2 = 32'h0F0F_0F0F;
    tick();
    alu_op = 4'b0011; op1 = 32'd9; op2 = 32'd9;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (!out_valid || alu_result !== 32'hAAAA_AAAA || in_ready) seen = 1'b1;
      tick();
    end
    chk("bp_stable", {31'd0, seen}, 32'd0);
    chk("bp_result", alu_result, 32'hAAAA_AAAA);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_drain", {31'd0, out_valid}, 32'd0);

    // Flush 10 cycles into a divide
    in_valid = 1'b1;
    alu_op = 4'b1110; op1 = 32'd100; op2 = 32'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_ready", {31'd0, in_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick();
    end
    chk("flush_no_valid", {31'd0, seen}, 32'd0);
    run_op("add_after_flush", 4'b0011, 32'd2, 32'd3, 1, 32'd5);

    // Flush wins over a simultaneous request
    flush    = 1'b1;
    in_valid = 1'b1;
    alu_op = 4'b0011; op1 = 32'd7; op2 = 32'd7;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_no_accept", {31'd0, out_valid}, 32'd0);
    tick();
    chk("flush_no_accept2", {31'd0, out_valid}, 32'd0);
    chk("flush_keeps_result", alu_result, 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
